// File: rtl/tiled_mm_if.sv
// Job/buffer bundle between a host and the tiled matrix-multiply controller.
// Member names carry the controller's view (_i into it, _o out of it).
interface tiled_mm_if #(
  parameter int ARRAY_DIM  = 8,
  parameter int ADDR_WIDTH = 16
) ();
  logic                  start_i;
  logic                  stall_i;
  logic [ADDR_WIDTH-1:0] m_i;
  logic [ADDR_WIDTH-1:0] k_i;
  logic [ADDR_WIDTH-1:0] n_i;
  logic [ADDR_WIDTH-1:0] base_addra_i;
  logic [ADDR_WIDTH-1:0] base_addrb_i;
  logic [ADDR_WIDTH-1:0] base_addrp_i;
  logic                  busy_o;
  logic                  valid_o;
  logic                  pe_clear_o;
  logic                  pe_we_o;
  logic                  bubble_o;
  logic                  ena_o;
  logic                  enb_o;
  logic [ADDR_WIDTH-1:0] addra_o;
  logic [ADDR_WIDTH-1:0] addrb_o;
  logic                  enp_o;
  logic                  wep_o;
  logic [ADDR_WIDTH-1:0] addrp_o;
  logic [ARRAY_DIM-1:0]  row_en_o;
  logic [ARRAY_DIM-1:0]  col_en_o;

  modport slave (
    input  start_i, stall_i, m_i, k_i, n_i, base_addra_i, base_addrb_i, base_addrp_i,
    output busy_o, valid_o, pe_clear_o, pe_we_o, bubble_o, ena_o, enb_o, addra_o,
           addrb_o, enp_o, wep_o, addrp_o, row_en_o, col_en_o
  );

  modport master (
    output start_i, stall_i, m_i, k_i, n_i, base_addra_i, base_addrb_i, base_addrp_i,
    input  busy_o, valid_o, pe_clear_o, pe_we_o, bubble_o, ena_o, enb_o, addra_o,
           addrb_o, enp_o, wep_o, addrp_o, row_en_o, col_en_o
  );
endinterface

// File: rtl/tiled_mm_controller.sv
// Sequences a tiled A(m x k) * B(k x n) job over an ARRAY_DIM x ARRAY_DIM systolic array:
// operand reads, drain wait and result write-back per tile, row-major over the tile grid.
module tiled_mm_controller #(
  parameter int ARRAY_DIM  = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int OUTPUT_LAT = 3
) (
  input  logic      clk_i,
  input  logic      rst_i,
  tiled_mm_if.slave bus
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] DIM = AW'(ARRAY_DIM);
  localparam logic [AW-1:0] LAT = AW'(OUTPUT_LAT);
  localparam logic [AW-1:0] ONE = AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rows_left_q, rows_left_d;
  logic [AW-1:0] cols_left_q, cols_left_d;
  logic [AW-1:0] abase_q, abase_d;
  logic [AW-1:0] bbase_q, bbase_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          stall_q, stall_d;
  logic          armed_q, armed_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] n_q, n_d;
  logic [AW-1:0] base_b_q, base_b_d;

  logic [AW-1:0] tile_m, tile_n;
  logic [AW-1:0] read_len, read_last, wait_last, write_last;
  logic          last_row, last_col, active;

  function automatic logic [ARRAY_DIM-1:0] lane_mask(input logic [AW-1:0] len);
    logic [ARRAY_DIM-1:0] m;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      m[i] = (AW'(i) < len);
    end
    return m;
  endfunction

  // rows_left/cols_left count what remains of m/n from the current tile onward
  assign tile_m     = (rows_left_q > DIM) ? DIM : rows_left_q;
  assign tile_n     = (cols_left_q > DIM) ? DIM : cols_left_q;
  assign last_row   = (rows_left_q <= DIM);
  assign last_col   = (cols_left_q <= DIM);
  assign read_len   = (k_q > DIM) ? k_q : DIM;
  assign read_last  = read_len - ONE;
  assign wait_last  = LAT + tile_m - AW'(2);
  assign write_last = tile_n - ONE;
  assign active     = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_WRITE);

  // stall_q marks the displayed position as frozen: it is held and re-shown unmasked
  // on release, so a position advances only after it has been issued once.
  always_comb begin : next_state
    state_d     = state_q;
    cnt_d       = cnt_q;
    rows_left_d = rows_left_q;
    cols_left_d = cols_left_q;
    abase_d     = abase_q;
    bbase_d     = bbase_q;
    ptr_d       = ptr_q;
    k_d         = k_q;
    n_d         = n_q;
    base_b_d    = base_b_q;
    stall_d     = 1'b0;
    armed_d     = armed_q | ~bus.start_i;
    case (state_q)
      S_IDLE: begin
        if (armed_q && bus.start_i) begin
          k_d         = bus.k_i;
          n_d         = bus.n_i;
          base_b_d    = bus.base_addrb_i;
          rows_left_d = bus.m_i;
          cols_left_d = bus.n_i;
          abase_d     = bus.base_addra_i;
          bbase_d     = bus.base_addrb_i;
          ptr_d       = bus.base_addrp_i;
          cnt_d       = '0;
          if (bus.m_i == '0 || bus.k_i == '0 || bus.n_i == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            stall_d = bus.stall_i;
          end
        end
      end
      S_READ, S_WAIT, S_WRITE: begin
        stall_d = bus.stall_i;
        if (!stall_q) begin
          cnt_d = cnt_q + ONE;
          if (state_q == S_READ) begin
            if (cnt_q == read_last) begin
              state_d = S_WAIT;
              cnt_d   = '0;
            end
          end else if (state_q == S_WAIT) begin
            if (cnt_q == wait_last) begin
              state_d = S_WRITE;
              cnt_d   = '0;
            end
          end else begin
            ptr_d = ptr_q + ONE;
            if (cnt_q == write_last) begin
              cnt_d   = '0;
              state_d = S_READ;
              if (!last_col) begin
                cols_left_d = cols_left_q - DIM;
                bbase_d     = bbase_q + k_q;
              end else if (!last_row) begin
                rows_left_d = rows_left_q - DIM;
                abase_d     = abase_q + k_q;
                cols_left_d = n_q;
                bbase_d     = base_b_q;
              end else begin
                state_d = S_DONE;
                stall_d = 1'b0;
              end
            end
          end
        end
      end
      S_DONE: begin
        if (!bus.start_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rows_left_q <= '0;
      cols_left_q <= '0;
      abase_q     <= '0;
      bbase_q     <= '0;
      ptr_q       <= '0;
      stall_q     <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rows_left_q <= rows_left_d;
      cols_left_q <= cols_left_d;
      abase_q     <= abase_d;
      bbase_q     <= bbase_d;
      ptr_q       <= ptr_d;
      stall_q     <= stall_d;
      armed_q     <= armed_d;
    end
  end

  always_ff @(posedge clk_i) begin
    k_q      <= k_d;
    n_q      <= n_d;
    base_b_q <= base_b_d;
  end

  logic                 busy, valid, pe_clear, pe_we, bubble, ena, enb, enp, wep;
  logic [AW-1:0]        addra, addrb, addrp;
  logic [ARRAY_DIM-1:0] row_en, col_en;

  // Addresses read as zero outside the state that uses them so idle/reset outputs are all-zero.
  always_comb begin : outputs
    busy     = active;
    valid    = (state_q == S_DONE);
    pe_clear = 1'b0;
    pe_we    = 1'b0;
    bubble   = 1'b0;
    ena      = 1'b0;
    enb      = 1'b0;
    enp      = 1'b0;
    wep      = 1'b0;
    addra    = '0;
    addrb    = '0;
    addrp    = '0;
    row_en   = '0;
    col_en   = '0;
    if (active) begin
      row_en = lane_mask(tile_m);
      col_en = lane_mask(tile_n);
    end
    if (state_q == S_READ) begin
      ena      = ~stall_q;
      enb      = ~stall_q;
      addra    = abase_q + cnt_q;
      addrb    = bbase_q + cnt_q;
      pe_clear = ~stall_q & (cnt_q == '0);
      pe_we    = ~stall_q & (cnt_q == k_q - ONE);
      bubble   = (cnt_q >= k_q);
    end
    if (state_q == S_WRITE) begin
      enp   = ~stall_q;
      wep   = ~stall_q;
      addrp = ptr_q;
    end
  end

  assign bus.busy_o     = busy;
  assign bus.valid_o    = valid;
  assign bus.pe_clear_o = pe_clear;
  assign bus.pe_we_o    = pe_we;
  assign bus.bubble_o   = bubble;
  assign bus.ena_o      = ena;
  assign bus.enb_o      = enb;
  assign bus.addra_o    = addra;
  assign bus.addrb_o    = addrb;
  assign bus.enp_o      = enp;
  assign bus.wep_o      = wep;
  assign bus.addrp_o    = addrp;
  assign bus.row_en_o   = row_en;
  assign bus.col_en_o   = col_en;

endmodule
